// File: rtl/mem_access_pkg.sv
// Shared types and constants for the data-memory access unit.
package mem_access_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam int WORD_BYTES        = 4;
    localparam int MEM_BYTES_DEFAULT = 19;

    // Widen a loaded byte to 32 bits, zero- or sign-extended.
    function automatic logic [31:0] extend_byte(input logic [7:0] b, input logic is_unsigned);
        return is_unsigned ? {24'h000000, b} : {{24{b[7]}}, b};
    endfunction

endpackage

// File: rtl/mem_access_if.sv
// Pipeline request/response handshake plus the byte-wide data-memory port.
interface mem_access_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic        req_byte;
    logic        req_unsigned;
    logic [31:0] req_address;
    logic [31:0] req_write_data;
    logic        resp_valid;
    logic [31:0] resp_read_data;
    logic        resp_error;
    logic        stall;
    logic [31:0] address;
    logic [7:0]  write_data;
    logic        memRead;
    logic        memWrite;
    logic [7:0]  read_data;

    // Environment side: pipeline control plus the memory's read path.
    modport master (
        output req_valid, req_write, req_byte, req_unsigned, req_address, req_write_data,
        output read_data,
        input  req_ready, resp_valid, resp_read_data, resp_error, stall,
        input  address, write_data, memRead, memWrite
    );

    // Access-unit side.
    modport slave (
        input  req_valid, req_write, req_byte, req_unsigned, req_address, req_write_data,
        input  read_data,
        output req_ready, resp_valid, resp_read_data, resp_error, stall,
        output address, write_data, memRead, memWrite
    );

endinterface

// File: rtl/mem_access_unit.sv
// Splits one word/byte load or store into single-byte memory strobes and stalls until done.
// Optional MEM_ACCESS_BYTE_EN enables byte accesses; without it every access is an aligned word.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int MEM_BYTES = MEM_BYTES_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    mem_access_if.slave  bus
);

    state_t      state_reg, state_next;
    logic [1:0]  idx_reg, idx_next;
    logic        write_reg, byte_reg, unsigned_reg, error_reg;
    logic [31:0] addr_reg, wdata_reg;
    logic [7:0]  lane_reg [WORD_BYTES];

    logic        req_byte_eff, req_unsigned_eff;
    logic [2:0]  req_n;
    logic [32:0] req_end;
    logic        req_error;
    logic        accept;
    logic [1:0]  last_idx;
    logic [31:0] wdata_shift;
    logic [31:0] word_data;

`ifdef MEM_ACCESS_BYTE_EN
    assign req_byte_eff     = bus.req_byte;
    assign req_unsigned_eff = bus.req_unsigned;
`else
    logic unused_byte_ctrl;
    assign unused_byte_ctrl = bus.req_byte ^ bus.req_unsigned;
    assign req_byte_eff     = 1'b0;
    assign req_unsigned_eff = 1'b0;
`endif

    // The end-of-access check is done in 33 bits so addresses near 2^32 cannot wrap into range.
    assign req_n     = req_byte_eff ? 3'd1 : 3'd4;
    assign req_end   = {1'b0, bus.req_address} + {30'b0, req_n};
    assign req_error = (!req_byte_eff && (bus.req_address[1:0] != 2'b00)) ||
                       (req_end > 33'(MEM_BYTES));
    assign accept    = (state_reg == IDLE) && bus.req_valid;
    assign last_idx  = byte_reg ? 2'd0 : 2'd3;

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        case (state_reg)
            IDLE: begin
                if (bus.req_valid) begin
                    state_next = req_error ? DONE : ACCESS;
                    idx_next   = 2'd0;
                end
            end
            ACCESS: begin
                idx_next = idx_reg + 2'd1;
                if (idx_reg == last_idx) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                idx_next   = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            idx_reg      <= 2'd0;
            write_reg    <= 1'b0;
            byte_reg     <= 1'b0;
            unsigned_reg <= 1'b0;
            error_reg    <= 1'b0;
            addr_reg     <= 32'h0;
            wdata_reg    <= 32'h0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            if (accept) begin
                write_reg    <= bus.req_write;
                byte_reg     <= req_byte_eff;
                unsigned_reg <= req_unsigned_eff;
                error_reg    <= req_error;
                addr_reg     <= bus.req_address;
                wdata_reg    <= bus.req_write_data;
            end
        end
    end

    // One capture register per byte lane; a load fills lane idx on each ACCESS cycle.
    for (genvar gi = 0; gi < WORD_BYTES; gi++) begin : g_lane
        always_ff @(posedge clk) begin
            if (reset) begin
                lane_reg[gi] <= 8'h00;
            end else if (accept) begin
                lane_reg[gi] <= 8'h00;
            end else if (state_reg == ACCESS && !write_reg && idx_reg == 2'(gi)) begin
                lane_reg[gi] <= bus.read_data;
            end
        end
    end

    assign word_data   = {lane_reg[3], lane_reg[2], lane_reg[1], lane_reg[0]};
    assign wdata_shift = wdata_reg >> {idx_reg, 3'b000};

    always_comb begin
        bus.req_ready      = 1'b0;
        bus.stall          = 1'b1;
        bus.resp_valid     = 1'b0;
        bus.resp_error     = 1'b0;
        bus.resp_read_data = 32'h0;
        bus.memRead        = 1'b0;
        bus.memWrite       = 1'b0;
        bus.address        = 32'h0;
        bus.write_data     = 8'h00;
        case (state_reg)
            IDLE: begin
                bus.req_ready = 1'b1;
                bus.stall     = 1'b0;
            end
            ACCESS: begin
                // Strobes are gated by reset so an aborted access stops writing in the same cycle.
                bus.address    = addr_reg + {30'b0, idx_reg};
                bus.write_data = write_reg ? wdata_shift[7:0] : 8'h00;
                bus.memWrite   = write_reg && !reset;
                bus.memRead    = !write_reg && !reset;
            end
            DONE: begin
                bus.resp_valid = 1'b1;
                bus.resp_error = error_reg;
                if (!error_reg && !write_reg) begin
                    bus.resp_read_data = byte_reg ? extend_byte(lane_reg[0], unsigned_reg)
                                                  : word_data;
                end
            end
            default: begin
                bus.stall = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: vector table, corner sequences, random vs. reference model.
module tb_mem_access_unit;

    localparam int MEMB = 19;
`ifdef MEM_ACCESS_BYTE_EN
    localparam bit BYTE_EN = 1'b1;
`else
    localparam bit BYTE_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    mem_access_if bus();

    mem_access_unit #(.MEM_BYTES(MEMB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Byte-wide data memory attached to the unit.
    logic [7:0] tb_mem [0:MEMB-1] = '{default: 8'h00};
    always @(posedge clk) begin
        if (bus.memWrite && bus.address < 32'(MEMB))
            tb_mem[bus.address[4:0]] <= bus.write_data;
    end
    always_comb begin
        bus.read_data = 8'h00;
        if (bus.memRead && bus.address < 32'(MEMB))
            bus.read_data = tb_mem[bus.address[4:0]];
    end

    // Reference memory image as the specification says it should look.
    logic [7:0] ref_mem [0:MEMB-1] = '{default: 8'h00};

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Behavioural model: decides outcome from the request alone and updates ref_mem.
    task automatic model(input logic w, input logic b, input logic u,
                         input logic [31:0] a, input logic [31:0] d,
                         output logic [31:0] ed, output logic ee, output int el, output int en);
        int n;
        longint last;
        n    = (BYTE_EN && b) ? 1 : 4;
        last = longint'(a) + n;
        ee   = (n == 4 && a % 4 != 0) || (last > MEMB);
        ed   = 32'h0;
        if (ee) begin
            el = 1;
            en = 0;
        end else begin
            el = n + 1;
            en = n;
            if (w) begin
                for (int i = 0; i < n; i++) ref_mem[int'(a) + i] = 8'((d >> (8 * i)) & 32'hFF);
            end else if (n == 4) begin
                for (int i = 0; i < 4; i++) ed = ed | (32'(ref_mem[int'(a) + i]) << (8 * i));
            end else begin
                ed = 32'(ref_mem[int'(a)]);
                if (!u && ed >= 32'h80) ed = ed + 32'hFFFFFF00;
            end
        end
    endtask

    // Issues one request from an idle cycle and follows it to its response.
    task automatic do_req(input logic w, input logic b, input logic u,
                          input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rdata, output logic rerr,
                          output int lat, output int nstb);
        logic [31:0] sh;
        bit got;
        bus.req_valid      = 1'b1;
        bus.req_write      = w;
        bus.req_byte       = b;
        bus.req_unsigned   = u;
        bus.req_address    = a;
        bus.req_write_data = d;
        chk("ready_idle", 32'(bus.req_ready), 32'd1);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        lat = 0; nstb = 0; rdata = 32'h0; rerr = 1'b0; got = 1'b0;
        for (int k = 1; k <= 8 && !got; k++) begin
            chk("stall_busy", 32'(bus.stall), 32'd1);
            chk("strobe_excl", 32'(bus.memRead & bus.memWrite), 32'd0);
            if (bus.memRead || bus.memWrite) begin
                chk("strobe_addr", bus.address, a + 32'(nstb));
                chk("strobe_kind", 32'(bus.memWrite), 32'(w));
                if (w) begin
                    sh = d >> (8 * nstb);
                    chk("strobe_wdata", 32'(bus.write_data), 32'(sh[7:0]));
                end
                nstb++;
            end
            if (bus.resp_valid) begin
                got   = 1'b1;
                lat   = k;
                rdata = bus.resp_read_data;
                rerr  = bus.resp_error;
            end else begin
                @(posedge clk); #1;
            end
        end
        @(posedge clk); #1;
        chk("ready_after", 32'(bus.req_ready), 32'd1);
        chk("resp_pulse", 32'(bus.resp_valid), 32'd0);
    endtask

    typedef struct {
        logic        w, b, u;
        logic [31:0] a, d;
        logic [31:0] exp_data;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vecs[$];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd, ed, ed2;
        logic        re, ee;
        int          lat, nst, el, en;
        int          reads;

        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_byte = 1'b0;
        bus.req_unsigned = 1'b0; bus.req_address = 32'h0; bus.req_write_data = 32'h0;

        vecs.push_back('{1'b1, 1'b0, 1'b0, 32'd0,  32'h0BADF00D, 32'h0,        1'b0, 5});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 32'd4,  32'hA1B2C3D4, 32'h0,        1'b0, 5});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 32'd4,  32'h0,        32'hA1B2C3D4, 1'b0, 5});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 32'd6,  32'h0,        32'h0,        1'b1, 1});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 32'd16, 32'h0,        32'h0,        1'b1, 1});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 32'd12, 32'h55667788, 32'h0,        1'b0, 5});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 32'd12, 32'h0,        32'h55667788, 1'b0, 5});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 32'd15, 32'hDEADBEEF, 32'h0,        1'b1, 1});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 32'd0,  32'h0,        32'h0BADF00D, 1'b0, 5});
`ifdef MEM_ACCESS_BYTE_EN
        vecs.push_back('{1'b0, 1'b1, 1'b0, 32'd7,  32'h0,        32'hFFFFFFA1, 1'b0, 2});
        vecs.push_back('{1'b0, 1'b1, 1'b1, 32'd7,  32'h0,        32'h000000A1, 1'b0, 2});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 32'd18, 32'h12345680, 32'h0,        1'b0, 2});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 32'd18, 32'h0,        32'hFFFFFF80, 1'b0, 2});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 32'd19, 32'h0,        32'h0,        1'b1, 1});
        vecs.push_back('{1'b0, 1'b1, 1'b1, 32'd5,  32'h0,        32'h000000C3, 1'b0, 2});
`else
        vecs.push_back('{1'b0, 1'b1, 1'b0, 32'd4,  32'h0,        32'hA1B2C3D4, 1'b0, 5});
        vecs.push_back('{1'b0, 1'b1, 1'b1, 32'd7,  32'h0,        32'h0,        1'b1, 1});
`endif

        // Reset and idle state
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk); #1;
        chk("rst_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_stall", 32'(bus.stall), 32'd0);
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_resp_error", 32'(bus.resp_error), 32'd0);
        chk("rst_resp_data", bus.resp_read_data, 32'h0);
        chk("rst_memread", 32'(bus.memRead), 32'd0);
        chk("rst_memwrite", 32'(bus.memWrite), 32'd0);
        chk("rst_address", bus.address, 32'h0);
        chk("rst_wdata", 32'(bus.write_data), 32'h0);

        // Directed vector table
        foreach (vecs[i]) begin
            model(vecs[i].w, vecs[i].b, vecs[i].u, vecs[i].a, vecs[i].d, ed, ee, el, en);
            do_req(vecs[i].w, vecs[i].b, vecs[i].u, vecs[i].a, vecs[i].d, rd, re, lat, nst);
            $display("vec %0d: w=%0d b=%0d u=%0d a=%0d d=%08h -> data=%08h err=%0d lat=%0d strobes=%0d",
                     i, vecs[i].w, vecs[i].b, vecs[i].u, vecs[i].a, vecs[i].d, rd, re, lat, nst);
            chk("vec_data", rd, vecs[i].exp_data);
            chk("vec_err", 32'(re), 32'(vecs[i].exp_err));
            chk("vec_lat", 32'(lat), 32'(vecs[i].exp_lat));
            chk("vec_strobes", 32'(nst), vecs[i].exp_err ? 32'd0 : 32'(vecs[i].exp_lat - 1));
        end

        // Back-to-back word loads with req_valid held high
        model(1'b0, 1'b0, 1'b0, 32'd4, 32'h0, ed, ee, el, en);
        model(1'b0, 1'b0, 1'b0, 32'd0, 32'h0, ed2, ee, el, en);
        bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_byte = 1'b0;
        bus.req_unsigned = 1'b0; bus.req_address = 32'd4;
        @(posedge clk); #1;
        bus.req_address = 32'd0;
        reads = 0;
        for (int k = 1; k <= 12; k++) begin
            chk("b2b_stall", 32'(bus.stall), (k == 6 || k == 12) ? 32'd0 : 32'd1);
            chk("b2b_resp_valid", 32'(bus.resp_valid), (k == 5 || k == 11) ? 32'd1 : 32'd0);
            if (bus.memRead) reads++;
            if (k == 5) chk("b2b_data1", bus.resp_read_data, ed);
            if (k == 11) chk("b2b_data2", bus.resp_read_data, ed2);
            @(posedge clk); #1;
            if (k == 6) bus.req_valid = 1'b0;
        end
        chk("b2b_reads", 32'(reads), 32'd8);
        $display("b2b: two word loads, %0d read strobes", reads);

        // Reset during the second ACCESS cycle of a word store to 8
        model(1'b1, 1'b0, 1'b0, 32'd8, 32'hCAFEBABE, ed, ee, el, en);
        do_req(1'b1, 1'b0, 1'b0, 32'd8, 32'hCAFEBABE, rd, re, lat, nst);
        bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_byte = 1'b0;
        bus.req_address = 32'd8; bus.req_write_data = 32'h11223344;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        chk("rst_mid_addr0", bus.address, 32'd8);
        chk("rst_mid_we0", 32'(bus.memWrite), 32'd1);
        @(posedge clk); #1;
        chk("rst_mid_addr1", bus.address, 32'd9);
        reset = 1'b1;
        #1;
        chk("rst_mid_we_drop", 32'(bus.memWrite), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        ref_mem[8] = 8'h44;
        chk("rst_mid_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_mid_stall", 32'(bus.stall), 32'd0);
        for (int k = 0; k < 6; k++) begin
            chk("rst_mid_no_resp", 32'(bus.resp_valid), 32'd0);
            chk("rst_mid_no_strobe", 32'(bus.memWrite | bus.memRead), 32'd0);
            @(posedge clk); #1;
        end
        for (int i = 8; i < 12; i++) chk("rst_mid_mem", 32'(tb_mem[i]), 32'(ref_mem[i]));
        $display("reset-abort: mem[8..11]=%02h %02h %02h %02h", tb_mem[8], tb_mem[9], tb_mem[10], tb_mem[11]);

        // Randomized requests against the reference model
        for (int t = 0; t < 60; t++) begin
            logic        w, b, u;
            logic [31:0] a, d;
            w = 1'($urandom_range(0, 1));
            b = 1'($urandom_range(0, 1));
            u = 1'($urandom_range(0, 1));
            a = 32'($urandom_range(0, 21));
            d = $urandom;
            model(w, b, u, a, d, ed, ee, el, en);
            do_req(w, b, u, a, d, rd, re, lat, nst);
            $display("rnd %0d: w=%0d b=%0d u=%0d a=%0d d=%08h -> data=%08h err=%0d lat=%0d",
                     t, w, b, u, a, d, rd, re, lat);
            chk("rnd_data", rd, ed);
            chk("rnd_err", 32'(re), 32'(ee));
            chk("rnd_lat", 32'(lat), 32'(el));
            chk("rnd_strobes", 32'(nst), 32'(en));
        end
        for (int i = 0; i < MEMB; i++) chk("final_mem", 32'(tb_mem[i]), 32'(ref_mem[i]));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
